alu_cmd_sequencer: RTL and testbench

Command-driven front end for the 16-bit structural ALU. It accepts one register-transfer command per handshake and holds a 4-entry, 16-bit register file. It drives the ALU operand, carry and opcode inputs from registers, then writes the ALU result and Z/N flags back into the file. It sits directly upstream of the ALU and closes the loop on its outputs, turning the combinational ALU into a small accumulator-style datapath.

---
 rtl/alu_cmd_sequencer.sv | 109 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command front end for the structural ALU: 4-entry register file,
// registered ALU operands and write-back of result and Z/N flags.
module alu_cmd_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_kind,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_cin,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [AW-1:0]    cmd_src1,
  input  logic [AW-1:0]    cmd_src2,
  input  logic             cmd_imm_sel,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_w,
  input  logic             alu_z,
  input  logic             alu_n,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             z_flag,
  output logic             n_flag,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t             state;
  logic [WIDTH-1:0]   rf [NREG];
  logic [AW-1:0]      dst_q;
  logic               kind_q;
  logic [WIDTH-1:0]   imm_q;
  logic [WIDTH-1:0]   wb_data;
  logic               wb_z;
  logic               wb_n;

  assign rd_data = rf[rd_addr];

  always_comb begin
    wb_data = alu_w;
    wb_z    = alu_z;
    wb_n    = alu_n;
    if (kind_q) begin
      wb_data = imm_q;
      wb_z    = (imm_q == '0);
      wb_n    = imm_q[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
      alu_op    <= '0;
      dst_q     <= '0;
      kind_q    <= 1'b0;
      imm_q     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      z_flag    <= 1'b0;
      n_flag    <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            // operands sample the file before any write this edge
            alu_a     <= rf[cmd_src1];
            alu_b     <= cmd_imm_sel ? cmd_imm : rf[cmd_src2];
            alu_cin   <= cmd_cin;
            alu_op    <= cmd_op;
            dst_q     <= cmd_dst;
            kind_q    <= cmd_kind;
            imm_q     <= cmd_imm;
            state     <= EXEC;
            cmd_ready <= 1'b0;
          end
        end
        EXEC: begin
          rf[dst_q] <= wb_data;
          res_valid <= 1'b1;
          res_data  <= wb_data;
          z_flag    <= wb_z;
          n_flag    <= wb_n;
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with an adder ALU stub
// and a register-file reference model.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_kind;
  logic [2:0]  cmd_op;
  logic        cmd_cin;
  logic [1:0]  cmd_dst;
  logic [1:0]  cmd_src1;
  logic [1:0]  cmd_src2;
  logic        cmd_imm_sel;
  logic [15:0] cmd_imm;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cin;
  logic [2:0]  alu_op;
  logic [15:0] alu_w;
  logic        alu_z;
  logic        alu_n;
  logic        res_valid;
  logic [15:0] res_data;
  logic        z_flag;
  logic        n_flag;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [15:0] m_rf [4];
  logic        m_z;
  logic        m_n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign alu_w = alu_a + alu_b + {15'b0, alu_cin};
  assign alu_z = (alu_w == 16'h0000);
  assign alu_n = alu_w[15];

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_cin(cmd_cin),
    .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
    .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_w(alu_w), .alu_z(alu_z), .alu_n(alu_n),
    .res_valid(res_valid), .res_data(res_data),
    .z_flag(z_flag), .n_flag(n_flag),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Issue one command from a post-edge point; returns at a post-edge
  // point after write-back. hold keeps cmd_valid asserted throughout.
  task automatic do_cmd(input logic k, input logic [2:0] op,
                        input logic ci, input logic [1:0] d,
                        input logic [1:0] s1, input logic [1:0] s2,
                        input logic isel, input logic [15:0] imm,
                        input logic hold);
    logic [15:0] ea, eb, ew;
    ea = m_rf[s1];
    eb = isel ? imm : m_rf[s2];
    ew = k ? imm : 16'(ea + eb + {15'b0, ci});
    cmd_kind = k; cmd_op = op; cmd_cin = ci; cmd_dst = d;
    cmd_src1 = s1; cmd_src2 = s2; cmd_imm_sel = isel; cmd_imm = imm;
    cmd_valid = 1'b1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_idle: got %b want 1", cmd_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (cmd_ready !== 1'b0 || alu_a !== ea || alu_b !== eb ||
        alu_cin !== ci || alu_op !== op || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL exec: rdy=%b a=%h b=%h cin=%b op=%0d rv=%b want 0 %h %h %b %0d 0",
               cmd_ready, alu_a, alu_b, alu_cin, alu_op, res_valid,
               ea, eb, ci, op);
    end
    if (!hold) cmd_valid = 1'b0;
    @(posedge clk); #1;
    m_rf[d] = ew;
    m_z = (ew == 16'h0000);
    m_n = ew[15];
    vectors++;
    if (res_valid !== 1'b1 || res_data !== ew || z_flag !== m_z ||
        n_flag !== m_n || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL writeback: rv=%b data=%h z=%b n=%b rdy=%b want 1 %h %b %b 1",
               res_valid, res_data, z_flag, n_flag, cmd_ready, ew, m_z, m_n);
    end
    rd_addr = d; #1;
    vectors++;
    if (rd_data !== ew) begin
      errors++;
      $display("FAIL rd_dst: r%0d got %h want %h", d, rd_data, ew);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) m_rf[i] = 16'h0;
    m_z = 1'b0; m_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      vectors++;
      if (rd_data !== 16'h0) begin
        errors++;
        $display("FAIL reset_rf: r%0d got %h want 0000", i, rd_data);
      end
    end
    vectors++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || z_flag !== 1'b0 ||
        n_flag !== 1'b0 || alu_a !== 16'h0 || alu_b !== 16'h0 ||
        alu_cin !== 1'b0 || alu_op !== 3'd0 || res_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_out: rdy=%b rv=%b z=%b n=%b a=%h b=%h want 1 0 0 0 0 0",
               cmd_ready, res_valid, z_flag, n_flag, alu_a, alu_b);
    end
  endtask

  task automatic test_load;
    do_cmd(1'b1, 3'd0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0005, 1'b0);
    vectors++;
    if (res_data !== 16'h0005) begin
      errors++;
      $display("FAIL load_r1: got %h want 0005", res_data);
    end
    @(posedge clk); #1;
    vectors++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: res_valid got %b want 0", res_valid);
    end
    do_cmd(1'b1, 3'd0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b0, 16'h0003, 1'b0);
    rd_addr = 2'd1; #1;
    vectors++;
    if (rd_data !== 16'h0005) begin
      errors++;
      $display("FAIL rd_r1: got %h want 0005", rd_data);
    end
    rd_addr = 2'd2; #1;
    vectors++;
    if (rd_data !== 16'h0003) begin
      errors++;
      $display("FAIL rd_r2: got %h want 0003", rd_data);
    end
  endtask

  task automatic test_alu;
    do_cmd(1'b0, 3'd2, 1'b1, 2'd3, 2'd1, 2'd2, 1'b0, 16'h1234, 1'b0);
    vectors++;
    if (rd_data !== 16'h0009 || z_flag !== 1'b0 || n_flag !== 1'b0) begin
      errors++;
      $display("FAIL alu_r3: got %h z=%b n=%b want 0009 0 0",
               rd_data, z_flag, n_flag);
    end
  endtask

  task automatic test_imm_wrap;
    do_cmd(1'b0, 3'd0, 1'b0, 2'd3, 2'd3, 2'd0, 1'b1, 16'hFFF7, 1'b0);
    vectors++;
    if (rd_data !== 16'h0000 || z_flag !== 1'b1) begin
      errors++;
      $display("FAIL wrap_r3: got %h z=%b want 0000 1", rd_data, z_flag);
    end
  endtask

  task automatic test_negative;
    do_cmd(1'b0, 3'd5, 1'b0, 2'd0, 2'd1, 2'd0, 1'b1, 16'h8000, 1'b0);
    vectors++;
    if (rd_data !== 16'h8005 || n_flag !== 1'b1) begin
      errors++;
      $display("FAIL neg_r0: got %h n=%b want 8005 1", rd_data, n_flag);
    end
  endtask

  task automatic test_back_to_back;
    int c0, c1, c2;
    c0 = cyc;
    do_cmd(1'b0, 3'd1, 1'b1, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0, 1'b1);
    c1 = cyc;
    do_cmd(1'b1, 3'd3, 1'b0, 2'd1, 2'd2, 2'd3, 1'b0, 16'h7FFF, 1'b1);
    c2 = cyc;
    do_cmd(1'b0, 3'd7, 1'b0, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (c1 - c0 != 2 || c2 - c1 != 2 || cyc - c2 != 2) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d %0d %0d want 2 2 2",
               c1 - c0, c2 - c1, cyc - c2);
    end
  endtask

  task automatic test_reset_mid;
    cmd_kind = 1'b1; cmd_op = 3'd0; cmd_cin = 1'b0; cmd_dst = 2'd2;
    cmd_src1 = 2'd0; cmd_src2 = 2'd0; cmd_imm_sel = 1'b0;
    cmd_imm = 16'h1234; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1; #1;
    for (int i = 0; i < 4; i++) m_rf[i] = 16'h0;
    m_z = 1'b0; m_n = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: rdy=%b rv=%b want 1 0", cmd_ready, res_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_nopulse: rv=%b rdy=%b want 0 1",
                 res_valid, cmd_ready);
      end
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      vectors++;
      if (rd_data !== 16'h0) begin
        errors++;
        $display("FAIL rst_rf: r%0d got %h want 0000", i, rd_data);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      do_cmd(1'($urandom), 3'($urandom), 1'($urandom),
             2'($urandom), 2'($urandom), 2'($urandom),
             1'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      vectors++;
      if (rd_data !== m_rf[i]) begin
        errors++;
        $display("FAIL rand_rf: r%0d got %h want %h", i, rd_data, m_rf[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_kind = 1'b0; cmd_op = 3'd0;
    cmd_cin = 1'b0; cmd_dst = 2'd0; cmd_src1 = 2'd0; cmd_src2 = 2'd0;
    cmd_imm_sel = 1'b0; cmd_imm = 16'h0; rd_addr = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_load;
    test_alu;
    test_imm_wrap;
    test_negative;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

endmodule
